// File: rtl/shreg_deser.sv
// rtl/shreg_deser.sv - serial-to-parallel frame receiver with one-entry output holding register
module shreg_deser #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  input  logic                   sin_en,
  input  logic                   sof,
  output logic [W-1:0]           dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [$clog2(W+1)-1:0] bit_cnt,
  output logic                   busy,
  output logic                   err_sync,
  output logic                   overrun
);

  localparam int CW = $clog2(W+1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t       state;
  logic [W-1:0] sr;
  logic [W-1:0] sr_next;
  logic         last_bit;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[W-2:0], sin};
    else           sr_next = {sin, sr[W-1:1]};
  end

  assign last_bit = (bit_cnt == CW'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      err_sync   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      err_sync <= 1'b0;
      overrun  <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (sin_en && sof) begin
            sr      <= sr_next;
            bit_cnt <= CW'(1);
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (sin_en) begin
            sr <= sr_next;
            if (sof) begin
              // Restart: the strobed bit becomes bit 0 of a fresh word.
              bit_cnt  <= CW'(1);
              err_sync <= 1'b1;
            end else if (last_bit) begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              // A word landing on a full, unconsumed holding register is dropped.
              if (!dout_valid || dout_ready) begin
                dout       <= sr_next;
                dout_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
